// File: rtl/processing_unit_gen2_pkg.sv
// rtl/processing_unit_gen2_pkg.sv - shared defaults, ALU opcodes and bus source encodings
package processing_unit_gen2_pkg;

  localparam int DEF_WORD_SIZE = 8;
  localparam int DEF_OP_SIZE   = 4;
  localparam int DEF_NUM_REGS  = 4;

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_AND = 2;
  localparam int OP_OR  = 3;
  localparam int OP_XOR = 4;
  localparam int OP_NOT = 5;
  localparam int OP_SHL = 6;
  localparam int OP_SHR = 7;

  localparam logic [1:0] B1_REG  = 2'd0;
  localparam logic [1:0] B1_PC   = 2'd1;
  localparam logic [1:0] B1_SP   = 2'd2;
  localparam logic [1:0] B1_ZERO = 2'd3;

  localparam logic [1:0] B2_ALU  = 2'd0;
  localparam logic [1:0] B2_BUS1 = 2'd1;
  localparam logic [1:0] B2_MEM  = 2'd2;
  localparam logic [1:0] B2_IMM  = 2'd3;

endpackage

// File: rtl/processing_unit_gen2_alu.sv
// rtl/processing_unit_gen2_alu.sv - combinational ALU, a = Y and b = bus_1
module alu_risc_gen2
  import processing_unit_gen2_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int OP_SIZE   = DEF_OP_SIZE
) (
  input  logic [OP_SIZE-1:0]   i_op,
  input  logic [WORD_SIZE-1:0] i_a,
  input  logic [WORD_SIZE-1:0] i_b,
  output logic [WORD_SIZE-1:0] o_result,
  output logic                 o_carry
);

  logic [WORD_SIZE:0] w_sum;
  logic [WORD_SIZE:0] w_diff;
  int                 w_op;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  // Top bit of the extended difference is the unsigned borrow (a < b)
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};
  assign w_op   = int'(i_op);

  always_comb begin
    o_result = i_b;
    o_carry  = 1'b0;
    case (w_op)
      OP_ADD: begin
        o_result = w_sum[WORD_SIZE-1:0];
        o_carry  = w_sum[WORD_SIZE];
      end
      OP_SUB: begin
        o_result = w_diff[WORD_SIZE-1:0];
        o_carry  = w_diff[WORD_SIZE];
      end
      OP_AND: o_result = i_a & i_b;
      OP_OR:  o_result = i_a | i_b;
      OP_XOR: o_result = i_a ^ i_b;
      OP_NOT: o_result = ~i_b;
      OP_SHL: begin
        o_result = {i_b[WORD_SIZE-2:0], 1'b0};
        o_carry  = i_b[WORD_SIZE-1];
      end
      OP_SHR: begin
        o_result = {1'b0, i_b[WORD_SIZE-1:1]};
        o_carry  = i_b[0];
      end
      default: o_result = i_b;
    endcase
  end

endmodule

// File: rtl/processing_unit_gen2.sv
// rtl/processing_unit_gen2.sv - two-bus datapath: register file, Y, IR, address, PC, SP and flags
module processing_unit_gen2
  import processing_unit_gen2_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int OP_SIZE   = DEF_OP_SIZE,
  parameter int NUM_REGS  = DEF_NUM_REGS,
  localparam int RSEL_W   = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] mem_word,
  input  logic                 reg_load,
  input  logic [RSEL_W-1:0]    reg_wsel,
  input  logic [RSEL_W-1:0]    reg_rsel,
  input  logic [1:0]           bus1_src,
  input  logic [1:0]           bus2_src,
  input  logic                 load_ir,
  input  logic                 load_add_r,
  input  logic                 load_reg_y,
  input  logic                 load_flags,
  input  logic                 load_pc,
  input  logic                 inc_pc,
  input  logic                 sp_push,
  input  logic                 sp_pop,
  output logic [WORD_SIZE-1:0] instruction,
  output logic [WORD_SIZE-1:0] address,
  output logic [WORD_SIZE-1:0] bus_1,
  output logic                 zflag,
  output logic                 cflag,
  output logic                 nflag,
  output logic                 sp_err
);

  localparam logic [WORD_SIZE-1:0] W_ONE = WORD_SIZE'(1);

  logic [WORD_SIZE-1:0] r_regs [NUM_REGS];
  logic [WORD_SIZE-1:0] r_y;
  logic [WORD_SIZE-1:0] r_ir;
  logic [WORD_SIZE-1:0] r_addr;
  logic [WORD_SIZE-1:0] r_pc;
  logic [WORD_SIZE-1:0] r_sp;
  logic                 r_z;
  logic                 r_c;
  logic                 r_n;
  logic                 r_sp_err;

  logic [WORD_SIZE-1:0] w_bus1;
  logic [WORD_SIZE-1:0] w_bus2;
  logic [WORD_SIZE-1:0] w_alu;
  logic                 w_carry;
  logic [OP_SIZE-1:0]   w_opcode;

  assign w_opcode = r_ir[WORD_SIZE-1 -: OP_SIZE];

  alu_risc_gen2 #(
    .WORD_SIZE(WORD_SIZE),
    .OP_SIZE  (OP_SIZE)
  ) u_alu (
    .i_op    (w_opcode),
    .i_a     (r_y),
    .i_b     (w_bus1),
    .o_result(w_alu),
    .o_carry (w_carry)
  );

  always_comb begin
    w_bus1 = '0;
    case (bus1_src)
      B1_REG:  w_bus1 = r_regs[reg_rsel];
      B1_PC:   w_bus1 = r_pc;
      B1_SP:   w_bus1 = r_sp;
      default: w_bus1 = '0;
    endcase
  end

  always_comb begin
    w_bus2 = '0;
    case (bus2_src)
      B2_ALU:  w_bus2 = w_alu;
      B2_BUS1: w_bus2 = w_bus1;
      B2_MEM:  w_bus2 = mem_word;
      default: w_bus2 = {{(WORD_SIZE-4){1'b0}}, r_ir[3:0]};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (reg_load) begin
      r_regs[reg_wsel] <= w_bus2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y    <= '0;
      r_ir   <= '0;
      r_addr <= '0;
      r_pc   <= '0;
      r_z    <= 1'b0;
      r_c    <= 1'b0;
      r_n    <= 1'b0;
    end else begin
      if (load_reg_y) r_y <= w_bus2;
      if (load_ir) r_ir <= w_bus2;
      if (load_add_r) r_addr <= w_bus2;
      if (load_pc) r_pc <= w_bus2;
      else if (inc_pc) r_pc <= r_pc + W_ONE;
      if (load_flags) begin
        r_z <= (w_alu == '0);
        r_c <= w_carry;
        r_n <= w_alu[WORD_SIZE-1];
      end
    end
  end

  // SP grows downward; a move past either end is refused and latched as an error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp     <= '1;
      r_sp_err <= 1'b0;
    end else if (sp_push && !sp_pop) begin
      if (r_sp == '0) r_sp_err <= 1'b1;
      else r_sp <= r_sp - W_ONE;
    end else if (sp_pop && !sp_push) begin
      if (r_sp == '1) r_sp_err <= 1'b1;
      else r_sp <= r_sp + W_ONE;
    end
  end

  assign instruction = r_ir;
  assign address     = r_addr;
  assign bus_1       = w_bus1;
  assign zflag       = r_z;
  assign cflag       = r_c;
  assign nflag       = r_n;
  assign sp_err      = r_sp_err;

endmodule

// File: tb/tb_processing_unit_gen2.sv
// tb/tb_processing_unit_gen2.sv - scoreboard bench for processing_unit_gen2 against a behavioural model
module tb_processing_unit_gen2;
  import processing_unit_gen2_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] mem_word = '0;
  logic       reg_load = 1'b0, reg_load8 = 1'b0;
  logic [1:0] reg_wsel = '0, reg_rsel = '0, bus1_src = '0, bus2_src = '0;
  logic [2:0] reg_wsel8 = '0, reg_rsel8 = '0;
  logic       load_ir = 0, load_add_r = 0, load_reg_y = 0, load_flags = 0;
  logic       load_pc = 0, inc_pc = 0, sp_push = 0, sp_pop = 0;
  logic [7:0] instruction, address, bus_1;
  logic       zflag, cflag, nflag, sp_err;
  logic [7:0] instruction8, address8, bus_1_8;
  logic       zflag8, cflag8, nflag8, sp_err8;

  always #5 clk = ~clk;

  processing_unit_gen2 dut (
    .clk(clk), .rst(rst), .mem_word(mem_word), .reg_load(reg_load),
    .reg_wsel(reg_wsel), .reg_rsel(reg_rsel), .bus1_src(bus1_src), .bus2_src(bus2_src),
    .load_ir(load_ir), .load_add_r(load_add_r), .load_reg_y(load_reg_y),
    .load_flags(load_flags), .load_pc(load_pc), .inc_pc(inc_pc),
    .sp_push(sp_push), .sp_pop(sp_pop), .instruction(instruction), .address(address),
    .bus_1(bus_1), .zflag(zflag), .cflag(cflag), .nflag(nflag), .sp_err(sp_err)
  );

  processing_unit_gen2 #(.NUM_REGS(8)) dut8 (
    .clk(clk), .rst(rst), .mem_word(mem_word), .reg_load(reg_load8),
    .reg_wsel(reg_wsel8), .reg_rsel(reg_rsel8), .bus1_src(bus1_src), .bus2_src(bus2_src),
    .load_ir(load_ir), .load_add_r(load_add_r), .load_reg_y(load_reg_y),
    .load_flags(load_flags), .load_pc(load_pc), .inc_pc(inc_pc),
    .sp_push(sp_push), .sp_pop(sp_pop), .instruction(instruction8), .address(address8),
    .bus_1(bus_1_8), .zflag(zflag8), .cflag(cflag8), .nflag(nflag8), .sp_err(sp_err8)
  );

  typedef struct {
    logic [7:0] mem;
    logic       rl, rl8, chk8, rst;
    logic [1:0] ws, rs, b1, b2;
    logic       ir, ar, y, fl, lpc, ipc, push, pop;
    logic [2:0] w8;
  } ctrl_t;

  typedef struct {
    string      nm;
    int         sel;
    logic [7:0] val;
    int         due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic [7:0] mon_got;
  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  int m_r[4], m_r8[8];
  int m_y, m_ir, m_addr, m_pc, m_sp;
  bit m_z, m_c, m_n, m_err;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pick(input int sel);
    case (sel)
      0: return bus_1;
      1: return {5'b0, zflag, cflag, nflag};
      2: return {7'b0, sp_err};
      3: return instruction;
      4: return address;
      default: return bus_1_8;
    endcase
  endfunction

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      mon_e = exp_q.pop_front();
      mon_got = pick(mon_e.sel);
      n_checks++;
      if (mon_got !== mon_e.val) begin
        n_errors++;
        $display("FAIL %s cycle %0d got %h expected %h", mon_e.nm, cyc, mon_got, mon_e.val);
      end
    end
  end

  task automatic expect_now(input string nm, input int sel, input int v);
    exp_q.push_back('{nm, sel, 8'(v), cyc});
  endtask

  function automatic int alu_ref(input int op, input int a, input int b, output bit cy);
    cy = 0;
    case (op)
      OP_ADD: begin cy = (a + b) > 255; return (a + b) % 256; end
      OP_SUB: begin cy = a < b; return (a - b + 256) % 256; end
      OP_AND: return a & b;
      OP_OR:  return a | b;
      OP_XOR: return a ^ b;
      OP_NOT: return 255 - b;
      OP_SHL: begin cy = b >= 128; return (b * 2) % 256; end
      OP_SHR: begin cy = b % 2; return b / 2; end
      default: return b;
    endcase
  endfunction

  task automatic model_reset();
    foreach (m_r[i]) m_r[i] = 0;
    foreach (m_r8[i]) m_r8[i] = 0;
    m_y = 0; m_ir = 0; m_addr = 0; m_pc = 0; m_sp = 255;
    m_z = 0; m_c = 0; m_n = 0; m_err = 0;
  endtask

  function automatic ctrl_t idle();
    ctrl_t c;
    c = '{default: '0};
    return c;
  endfunction

  // Drive one cycle of controls, queue checks of the state seen before the edge, then advance the model
  task automatic apply(input ctrl_t c);
    int b1, b2, res;
    bit cy;
    @(posedge clk);
    #1;
    mem_word = c.mem; reg_load = c.rl; reg_wsel = c.ws; reg_rsel = c.rs;
    bus1_src = c.b1; bus2_src = c.b2; load_ir = c.ir; load_add_r = c.ar;
    load_reg_y = c.y; load_flags = c.fl; load_pc = c.lpc; inc_pc = c.ipc;
    sp_push = c.push; sp_pop = c.pop; reg_load8 = c.rl8; reg_wsel8 = c.w8; reg_rsel8 = c.w8;
    if (c.rst) begin
      #1 rst = 1'b1;
      #1 rst = 1'b0;
      model_reset();
    end
    case (c.b1)
      B1_REG:  b1 = m_r[c.rs];
      B1_PC:   b1 = m_pc;
      B1_SP:   b1 = m_sp;
      default: b1 = 0;
    endcase
    res = alu_ref(m_ir / 16, m_y, b1, cy);
    case (c.b2)
      B2_ALU:  b2 = res;
      B2_BUS1: b2 = b1;
      B2_MEM:  b2 = int'(c.mem);
      default: b2 = m_ir % 16;
    endcase
    expect_now("bus_1", 0, b1);
    expect_now("flags", 1, {m_z, m_c, m_n});
    expect_now("sp_err", 2, m_err);
    expect_now("instruction", 3, m_ir);
    expect_now("address", 4, m_addr);
    if (c.chk8) expect_now("bus_1_n8", 5, m_r8[c.w8]);
    if (c.rl) m_r[c.ws] = b2;
    if (c.rl8) m_r8[c.w8] = int'(c.mem);
    if (c.y) m_y = b2;
    if (c.ir) m_ir = b2;
    if (c.ar) m_addr = b2;
    if (c.fl) begin m_z = (res == 0); m_n = res >= 128; m_c = cy; end
    if (c.lpc) m_pc = b2;
    else if (c.ipc) m_pc = (m_pc + 1) % 256;
    if (c.push && !c.pop) begin
      if (m_sp == 0) m_err = 1; else m_sp = m_sp - 1;
    end else if (c.pop && !c.push) begin
      if (m_sp == 255) m_err = 1; else m_sp = m_sp + 1;
    end
  endtask

  task automatic ld(input int tgt, input int idx, input logic [7:0] v);
    ctrl_t c;
    c = idle(); c.mem = v; c.b2 = B2_MEM;
    case (tgt)
      0: begin c.rl = 1; c.ws = 2'(idx); end
      1: c.y = 1;
      2: c.ir = 1;
      default: c.lpc = 1;
    endcase
    apply(c);
  endtask

  task automatic rd(input logic [1:0] src, input int rs);
    ctrl_t c;
    c = idle(); c.b1 = src; c.rs = 2'(rs);
    apply(c);
  endtask

  task automatic alu_to(input int rs, input int ws);
    ctrl_t c;
    c = idle(); c.b1 = B1_REG; c.rs = 2'(rs); c.fl = 1; c.b2 = B2_ALU; c.rl = 1; c.ws = 2'(ws);
    apply(c);
  endtask

  initial begin
    ctrl_t c;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state, then a reset pulse between edges after state has been disturbed
    rd(B1_SP, 0);
    expect_now("reset_sp", 0, 8'hFF);
    ld(3, 0, 8'h55); ld(2, 0, 8'h9C); ld(0, 1, 8'h77);
    c = idle(); c.mem = 8'h31; c.b2 = B2_MEM; c.ar = 1; c.fl = 1; c.push = 1; apply(c);
    c = idle(); c.b1 = B1_SP; c.rst = 1; c.ipc = 1; apply(c);
    expect_now("rst_pulse_sp", 0, 8'hFF);
    expect_now("rst_pulse_ir", 3, 8'h00);
    expect_now("rst_pulse_addr", 4, 8'h00);
    rd(B1_PC, 0);
    expect_now("pc_after_rst_inc", 0, 8'h01);
    rd(B1_REG, 1);
    expect_now("r1_after_rst", 0, 8'h00);

    // ADD with carry into R2
    ld(1, 0, 8'hF0); ld(0, 1, 8'h20); ld(2, 0, 8'(OP_ADD << 4));
    alu_to(1, 2);
    rd(B1_REG, 2);
    expect_now("add_r2", 0, 8'h10);
    expect_now("add_flags", 1, 3'b010);

    // SUB: equal operands then borrow
    ld(1, 0, 8'h05); ld(0, 1, 8'h05); ld(2, 0, 8'(OP_SUB << 4));
    alu_to(1, 2);
    rd(B1_REG, 2);
    expect_now("sub_zero_flags", 1, 3'b100);
    ld(1, 0, 8'h03);
    alu_to(1, 2);
    rd(B1_REG, 2);
    expect_now("sub_borrow_r2", 0, 8'hFE);
    expect_now("sub_borrow_flags", 1, 3'b011);

    // Same register read and written in one cycle shows the old value
    c = idle(); c.b1 = B1_REG; c.rs = 1; c.mem = 8'h99; c.b2 = B2_MEM; c.rl = 1; c.ws = 1; apply(c);
    expect_now("no_bypass", 0, 8'h05);
    rd(B1_REG, 1);
    expect_now("r1_written", 0, 8'h99);

    // PC wrap and load priority
    ld(3, 0, 8'hFF);
    c = idle(); c.ipc = 1; apply(c);
    rd(B1_PC, 0);
    expect_now("pc_wrap", 0, 8'h00);
    c = idle(); c.mem = 8'h40; c.b2 = B2_MEM; c.lpc = 1; c.ipc = 1; apply(c);
    rd(B1_PC, 0);
    expect_now("pc_load_prio", 0, 8'h40);

    // Immediate low nibble
    ld(2, 0, 8'h37);
    c = idle(); c.b2 = B2_IMM; c.rl = 1; c.ws = 3; apply(c);
    rd(B1_REG, 3);
    expect_now("imm_r3", 0, 8'h07);

    // Eight-register build: R7 write/read, R3 untouched
    c = idle(); c.mem = 8'hA5; c.b2 = B2_MEM; c.rl8 = 1; c.w8 = 3'd7; apply(c);
    c = idle(); c.w8 = 3'd7; c.chk8 = 1; apply(c);
    expect_now("n8_r7", 5, 8'hA5);
    c = idle(); c.w8 = 3'd3; c.chk8 = 1; apply(c);

    // Stack limits
    c = idle(); c.rst = 1; c.push = 1; c.pop = 1; apply(c);
    rd(B1_SP, 0);
    expect_now("push_pop_sp", 0, 8'hFF);
    expect_now("push_pop_err", 2, 8'h00);
    for (int i = 0; i < 255; i++) begin
      c = idle(); c.push = 1; apply(c);
    end
    rd(B1_SP, 0);
    expect_now("sp_bottom", 0, 8'h00);
    expect_now("sp_bottom_err", 2, 8'h00);
    c = idle(); c.push = 1; apply(c);
    rd(B1_SP, 0);
    expect_now("sp_over", 0, 8'h00);
    expect_now("sp_over_err", 2, 8'h01);
    c = idle(); c.pop = 1; apply(c);
    rd(B1_SP, 0);
    expect_now("sp_err_sticky", 2, 8'h01);
    c = idle(); c.rst = 1; c.pop = 1; apply(c);
    rd(B1_SP, 0);
    expect_now("sp_under", 0, 8'hFF);
    expect_now("sp_under_err", 2, 8'h01);

    // Randomized operation mix against the model
    c = idle(); c.rst = 1; apply(c);
    for (int i = 0; i < 300; i++) begin
      c = idle();
      c.mem = 8'($urandom);
      c.rl = 1'($urandom); c.ws = 2'($urandom); c.rs = 2'($urandom);
      c.b1 = 2'($urandom); c.b2 = 2'($urandom);
      c.ir = ($urandom_range(0, 3) == 0); c.ar = 1'($urandom); c.y = 1'($urandom);
      c.fl = 1'($urandom); c.lpc = ($urandom_range(0, 3) == 0); c.ipc = 1'($urandom);
      c.push = ($urandom_range(0, 3) == 0); c.pop = ($urandom_range(0, 3) == 0);
      apply(c);
    end
    apply(idle());

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain pending %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
